// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through byte FIFO feeding the UART transmitter, with sticky overflow flag.
// Optional low-watermark interrupt is enabled by defining UART_TX_FIFO_WMARK_EN.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_flush,
    input  logic [AW:0]   cfg_wmark,
    input  logic          ovf_clr,
    input  logic          wr_valid,
    input  logic [7:0]    wr_data,
    output logic          wr_ready,
    output logic          tx_valid,
    output logic [7:0]    tx_data,
    input  logic          tx_ready,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          full,
    output logic          ovf_err,
    output logic          wmark_irq
);
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        push, pop, ovf;

    assign level    = wr_ptr - rd_ptr;
    assign empty    = wr_ptr == rd_ptr;
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_ready = !full;
    assign tx_valid = !empty;
    assign tx_data  = mem[rd_ptr[AW-1:0]];
    assign push     = wr_valid && !full && !cfg_flush;
    assign pop      = tx_ready && !empty && !cfg_flush;
    assign ovf      = wr_valid && full && !cfg_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ovf_err <= 1'b0;
        end else begin
            wr_ptr  <= cfg_flush ? '0 : wr_ptr + (AW+1)'(push);
            rd_ptr  <= cfg_flush ? '0 : rd_ptr + (AW+1)'(pop);
            ovf_err <= ovf ? 1'b1 : ovf_clr ? 1'b0 : ovf_err;
        end
    end

    // storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

`ifdef UART_TX_FIFO_WMARK_EN
    assign wmark_irq = level <= cfg_wmark;
`else
    logic unused_wmark;
    assign unused_wmark = ^cfg_wmark;
    assign wmark_irq    = 1'b0;
`endif
endmodule
